// File: rtl/rename_regfile_if.sv
// rename_regfile_if: groups the issue, operand-read, commit and flush signals
// that pass between the ROB/issue stage and the rename register file.
//   master : ROB / issue stage. Drives issue_*, rs*_addr, commit_* and flush_start/from/to.
//   slave  : rename_regfile. Returns rs*_data/busy/tag and flush_busy.
interface rename_regfile_if #(
    parameter int unsigned TAG_W = 3,
    parameter int unsigned XLEN  = 32
);
    localparam int unsigned REG_AW = 5;

    logic              issue_load;
    logic              issue_rd_we;
    logic [REG_AW-1:0] issue_rd;
    logic [TAG_W-1:0]  issue_tag;

    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic              rs1_busy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [XLEN-1:0]   rs2_data;
    logic              rs2_busy;
    logic [TAG_W-1:0]  rs2_tag;

    logic              commit_load;
    logic [REG_AW-1:0] commit_rd;
    logic [TAG_W-1:0]  commit_tag;
    logic [XLEN-1:0]   commit_data;

    logic              flush_start;
    logic [TAG_W-1:0]  flush_from;
    logic [TAG_W-1:0]  flush_to;
    logic              flush_busy;

    modport master (
        output issue_load, issue_rd_we, issue_rd, issue_tag,
        output rs1_addr, rs2_addr,
        output commit_load, commit_rd, commit_tag, commit_data,
        output flush_start, flush_from, flush_to,
        input  rs1_data, rs1_busy, rs1_tag, rs2_data, rs2_busy, rs2_tag,
        input  flush_busy
    );

    modport slave (
        input  issue_load, issue_rd_we, issue_rd, issue_tag,
        input  rs1_addr, rs2_addr,
        input  commit_load, commit_rd, commit_tag, commit_data,
        input  flush_start, flush_from, flush_to,
        output rs1_data, rs1_busy, rs1_tag, rs2_data, rs2_busy, rs2_tag,
        output flush_busy
    );
endinterface

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file and rename table for the Tomasulo core.
// When an instruction issues, its rd is marked busy with its ROB tag. When it commits,
// the value is written and busy is cleared, provided rd still maps to that tag. A
// mispredict flush walks a per-ROB-entry undo log from youngest to oldest and restores
// the earlier mappings, one entry per cycle.
// Ports:
//   clk, rst : clock; asynchronous active-high reset
//   rf       : rename_regfile_if.slave, carrying the issue, rs1/rs2 read, commit and flush signals
// Optional build macro REGFILE_BYPASS_EN: a read of a register that is committing in the same
// cycle returns commit_data, and its busy flag drops when that commit clears busy.
module rename_regfile #(
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned TAG_W     = 3,
    parameter int unsigned XLEN      = 32
) (
    input  logic             clk,
    input  logic             rst,
    rename_regfile_if.slave  rf
);
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [XLEN-1:0]   data_q [NREG];
    logic [XLEN-1:0]   data_d [NREG];
    logic [TAG_W-1:0]  tag_q  [NREG];
    logic [TAG_W-1:0]  tag_d  [NREG];
    logic [NREG-1:0]   busy_q, busy_d;

    logic [ROB_DEPTH-1:0] log_vld_q, log_vld_d;
    logic [ROB_DEPTH-1:0] log_pbusy_q, log_pbusy_d;
    logic [REG_AW-1:0]    log_rd_q   [ROB_DEPTH];
    logic [REG_AW-1:0]    log_rd_d   [ROB_DEPTH];
    logic [TAG_W-1:0]     log_ptag_q [ROB_DEPTH];
    logic [TAG_W-1:0]     log_ptag_d [ROB_DEPTH];

    logic [1:0]       state_q, state_d;
    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic [TAG_W-1:0] last_q, last_d;

    logic flush_busy;
    logic issue_ok;
    logic issue_ren;
    logic commit_fire;
    logic commit_clr;

    assign flush_busy    = (state_q != S_IDLE);
    assign rf.flush_busy = flush_busy;

    // An issue is accepted only while no walk is in progress. It renames only a non-zero rd.
    assign issue_ok    = rf.issue_load & ~flush_busy;
    assign issue_ren   = issue_ok & rf.issue_rd_we & (rf.issue_rd != '0);
    assign commit_fire = rf.commit_load & (rf.commit_rd != '0);
    assign commit_clr  = commit_fire & (tag_q[rf.commit_rd] == rf.commit_tag)
                       & ~(issue_ren & (rf.issue_rd == rf.commit_rd));

    // Next-state logic. Commit is applied first, then the walk step, then the issue, so a same-cycle rename wins.
    always_comb begin
        data_d      = data_q;
        tag_d       = tag_q;
        busy_d      = busy_q;
        log_vld_d   = log_vld_q;
        log_pbusy_d = log_pbusy_q;
        log_rd_d    = log_rd_q;
        log_ptag_d  = log_ptag_q;
        state_d     = state_q;
        ptr_d       = ptr_q;
        last_d      = last_q;

        if (commit_fire) begin
            data_d[rf.commit_rd] = rf.commit_data;
            if (commit_clr) begin
                busy_d[rf.commit_rd] = 1'b0;
            end
            log_vld_d[rf.commit_tag] = 1'b0;
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                if (log_vld_q[i] && log_pbusy_q[i] && (log_ptag_q[i] == rf.commit_tag)) begin
                    log_pbusy_d[i] = 1'b0;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rf.flush_start) begin
                    ptr_d   = rf.flush_to - TAG_W'(1);
                    last_d  = rf.flush_from;
                    state_d = (rf.flush_from == rf.flush_to) ? S_DONE : S_WALK;
                end
            end
            S_WALK: begin
                // Restore only if this entry is still the live mapping. A producer that commits
                // in this same cycle is forwarded, so it cannot be restored as busy.
                if (log_vld_q[ptr_q] && (tag_q[log_rd_q[ptr_q]] == ptr_q)) begin
                    busy_d[log_rd_q[ptr_q]] = log_pbusy_q[ptr_q]
                        & ~(commit_fire & (rf.commit_tag == log_ptag_q[ptr_q]));
                    tag_d[log_rd_q[ptr_q]]  = log_ptag_q[ptr_q];
                end
                log_vld_d[ptr_q] = 1'b0;
                if (ptr_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q - TAG_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue_ok) begin
            if (issue_ren) begin
                log_vld_d[rf.issue_tag]   = 1'b1;
                log_rd_d[rf.issue_tag]    = rf.issue_rd;
                // A previous producer that commits in this same cycle is logged as not busy.
                log_pbusy_d[rf.issue_tag] = busy_q[rf.issue_rd]
                    & ~(commit_fire & (rf.commit_tag == tag_q[rf.issue_rd]));
                log_ptag_d[rf.issue_tag]  = tag_q[rf.issue_rd];
                busy_d[rf.issue_rd]       = 1'b1;
                tag_d[rf.issue_rd]        = rf.issue_tag;
            end else begin
                log_vld_d[rf.issue_tag] = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                log_rd_q[i]   <= '0;
                log_ptag_q[i] <= '0;
            end
            busy_q      <= '0;
            log_vld_q   <= '0;
            log_pbusy_q <= '0;
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            last_q      <= '0;
        end else begin
            data_q      <= data_d;
            tag_q       <= tag_d;
            busy_q      <= busy_d;
            log_vld_q   <= log_vld_d;
            log_pbusy_q <= log_pbusy_d;
            log_rd_q    <= log_rd_d;
            log_ptag_q  <= log_ptag_d;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
        end
    end

    // Read port 1. x0 always reads as zero and not busy.
    always_comb begin
        rf.rs1_data = (rf.rs1_addr == '0) ? '0 : data_q[rf.rs1_addr];
        rf.rs1_busy = (rf.rs1_addr != '0) & busy_q[rf.rs1_addr];
`ifdef REGFILE_BYPASS_EN
        if (commit_fire && (rf.commit_rd == rf.rs1_addr)) begin
            rf.rs1_data = rf.commit_data;
            if (commit_clr) begin
                rf.rs1_busy = 1'b0;
            end
        end
`endif
        rf.rs1_tag = rf.rs1_busy ? tag_q[rf.rs1_addr] : '0;
    end

    // Read port 2
    always_comb begin
        rf.rs2_data = (rf.rs2_addr == '0) ? '0 : data_q[rf.rs2_addr];
        rf.rs2_busy = (rf.rs2_addr != '0) & busy_q[rf.rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (commit_fire && (rf.commit_rd == rf.rs2_addr)) begin
            rf.rs2_data = rf.commit_data;
            if (commit_clr) begin
                rf.rs2_busy = 1'b0;
            end
        end
`endif
        rf.rs2_tag = rf.rs2_busy ? tag_q[rf.rs2_addr] : '0;
    end
endmodule
